seq_mult_ctrl: RTL and testbench

Operand sequencer placed directly upstream of the team's 8×8 shift-add sequential multiplier. It accepts operand pairs over a valid/ready handshake and drives the multiplier's `A`/`B`/`enable` through a fixed load-then-run sequence. It captures the 16-bit product and presents it on a valid/ready result port. This adds flow control and a reset to a multiplier that has neither.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_mult_ctrl.sv | 105 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the sequential-multiplier operand sequencer.
package seq_mult_pkg;

    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int MUL_STEPS = 8;
    localparam int STEP_W    = $clog2(MUL_STEPS);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        HOLD
    } seq_mult_state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Operand sequencer for the 8x8 shift-add multiplier: valid/ready in, fixed
// load-then-run sequence to the multiplier, registered product out.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// LOAD  | mul_en low one cycle: multiplier clears and latches op_b
// RUN   | mul_en high for MUL_STEPS edges, one shift-add step each
// CAPT  | mul_en low, mul_c final; captured at the closing edge
// HOLD  | out_valid high until the consumer takes the product
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_en,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_data
);

    seq_mult_state_t     r_state;
    logic [OP_W-1:0]     r_op_a;
    logic [OP_W-1:0]     r_op_b;
    logic [STEP_W-1:0]   r_step_cnt;
    logic                r_mul_en;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [PROD_W-1:0]   r_out_data;

    logic w_accept;
    logic w_out_hs;

    assign w_accept = in_valid && r_in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_step_cnt  <= '0;
            r_mul_en    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a     <= in_a;
                        r_op_b     <= in_b;
                        r_in_ready <= 1'b0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_step_cnt <= '0;
                    r_mul_en   <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_step_cnt <= r_step_cnt + STEP_W'(1);
                    if (r_step_cnt == STEP_LAST) begin
                        r_mul_en <= 1'b0;
                        r_state  <= CAPT;
                    end
                end
                // The multiplier clears at this same edge; the pre-edge product is what lands here.
                CAPT: begin
                    r_out_data  <= mul_c;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_mul_en    <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_en    = r_mul_en;
    assign mul_a     = r_op_a;
    assign mul_b     = r_op_b;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl with a behavioural shift-add multiplier
// beside it and a scoreboard of expected products keyed on accepted pairs.
module tb_seq_mult_ctrl;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_a     = 8'd0;
    logic [7:0]  in_b     = 8'd0;
    logic        in_ready;
    logic        mul_en;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        out_valid;
    logic [15:0] out_data;

    logic [15:0] m_c  = 16'd0;
    logic [7:0]  m_b  = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_hs    = 0;
    int acc_edge = 0;
    int hs_edge  = 0;
    int en_cnt   = 0;
    bit prev_ov  = 1'b0;
    logic [15:0] held = 16'd0;
    logic [15:0] exp_q[$];
    int          acc_q[$];

    seq_mult_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (m_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Multiplier model: enable low clears and latches B, enable high does one MSB-first step.
    always @(posedge clk) begin
        if (!mul_en) begin
            m_c <= 16'd0;
            m_b <= mul_b;
        end else begin
            m_c <= {m_c[14:0], 1'b0} + (m_b[7] ? {8'd0, mul_a} : 16'd0);
            m_b <= {m_b[6:0], 1'b0};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            en_cnt  = 0;
            prev_ov = 1'b0;
        end else begin
            if (mul_en) en_cnt++;
            if (out_valid && !prev_ov) begin
                n_tests++;
                if (acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 data=%h, required no result pending", out_data);
                end else begin
                    int lat;
                    lat = cyc - acc_q.pop_front();
                    if (lat !== 10) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, required 10", lat);
                    end
                end
                n_tests++;
                if (en_cnt !== 8) begin
                    n_fail++;
                    $display("FAIL mul_en_cycles: got %0d, required 8", en_cnt);
                end
                held = out_data;
            end
            if (out_valid && prev_ov) begin
                n_tests++;
                if (out_data !== held || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_stable: got data=%h in_ready=%b, required data=%h in_ready=0",
                             out_data, in_ready, held);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL product: got %h, required nothing (queue empty)", out_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL product: got %h, required %h", out_data, e);
                    end
                end
                hs_edge = cyc + 1;
                n_hs++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(in_a) * 16'(in_b));
                acc_q.push_back(cyc + 1);
                acc_edge = cyc + 1;
                en_cnt   = 0;
                n_acc++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int start;
        bit ok;
        start = n_acc;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (n_acc != start) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: got no accept of %0d x %0d, required accept within 40 cycles", a, b);
        end
    endtask

    task automatic wait_ov(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=0, required 1 within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mul_en !== 1'b0 || out_data !== 16'd0 ||
            mul_a !== 8'd0 || mul_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b en=%b data=%h a=%h b=%h, required all 0",
                     out_valid, mul_en, out_data, mul_a, mul_b);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'd13, 8'd11);
        wait_ov("basic");
        n_tests++;
        if (out_data !== 16'h008F) begin
            n_fail++;
            $display("FAIL basic_data: got %h, required 008f", out_data);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_return_idle: got ov=%b in_ready=%b, required ov=0 in_ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [2] = '{8'd255, 8'd0};
        logic [7:0]  tb [2] = '{8'd255, 8'h80};
        logic [15:0] tp [2] = '{16'hFE01, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(ta[i], tb[i]);
            wait_ov("corner");
            n_tests++;
            if (out_data !== tp[i]) begin
                n_fail++;
                $display("FAIL corner_data: got %h, required %h", out_data, tp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int start;
        bit ok;
        out_ready = 1'b0;
        send(8'd7, 8'd9);
        wait_ov("bp");
        in_a = 8'd2;
        in_b = 8'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'h003F || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: got ov=%b data=%h in_ready=%b, required ov=1 data=003f in_ready=0",
                         out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        start = n_acc;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (n_acc != start) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (!ok || acc_edge !== hs_edge + 1) begin
            n_fail++;
            $display("FAIL bp_accept_order: got accept edge %0d handshake edge %0d, required accept one edge after handshake",
                     acc_edge, hs_edge);
        end
        wait_ov("bp2");
        n_tests++;
        if (out_data !== 16'h0004) begin
            n_fail++;
            $display("FAIL bp_next_data: got %h, required 0004", out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int start;
        int e1;
        int e2;
        bit got1;
        logic [15:0] d1;
        got1 = 1'b0;
        d1 = 16'hDEAD;
        e1 = 0;
        e2 = 0;
        out_ready = 1'b1;
        start = n_acc;
        in_a = 8'd3;
        in_b = 8'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && n_acc == start; i++) begin
            @(posedge clk); #1;
        end
        e1 = acc_edge;
        in_a = 8'd5;
        in_b = 8'd6;
        for (int i = 0; i < 40 && n_acc < start + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid && !got1) begin
                got1 = 1'b1;
                d1 = out_data;
            end
        end
        e2 = acc_edge;
        in_valid = 1'b0;
        n_tests++;
        if (n_acc != start + 2 || e2 - e1 !== 12) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d accepts %0d edges apart, required 2 accepts 12 apart",
                     n_acc - start, e2 - e1);
        end
        n_tests++;
        if (d1 !== 16'h000C) begin
            n_fail++;
            $display("FAIL b2b_first: got %h, required 000c", d1);
        end
        wait_ov("b2b");
        n_tests++;
        if (out_data !== 16'h001E) begin
            n_fail++;
            $display("FAIL b2b_second: got %h, required 001e", out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stray;
        out_ready = 1'b1;
        send(8'd9, 8'd9);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mul_en) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (!ok || mul_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_run: got mul_en=%b, required 1 at step 4", mul_en);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mul_en !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got mul_en=%b ov=%b, required both 0", mul_en, out_valid);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rst_mid_stray: got %0d cycles of out_valid, required 0", stray);
        end
        send(8'd10, 8'd10);
        wait_ov("rst_fresh");
        n_tests++;
        if (out_data !== 16'h0064) begin
            n_fail++;
            $display("FAIL rst_fresh_data: got %h, required 0064", out_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending results, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
